// File: rtl/log_mult_scheduler.sv
// log_mult_scheduler: shares one fixed-latency approximate log multiplier among
// NREQ requesters. It handles round-robin arbitration, sign/zero handling, tag
// tracking and in-order response buffering behind a credit check.
// Optional feature macro: LOG_MULT_SCHED_STATS_EN adds the stat_issued/stat_zero counters.
module log_mult_scheduler #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned OP_W       = 8,
  parameter int unsigned RES_W      = 16,
  parameter int unsigned DP_LAT     = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*OP_W-1:0]      req_a,
  input  logic [NREQ*OP_W-1:0]      req_b,
  output logic                      dp_valid,
  output logic [OP_W-1:0]           dp_a,
  output logic [OP_W-1:0]           dp_b,
  input  logic [RES_W-1:0]          dp_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [RES_W-1:0]          rsp_data,
  output logic                      idle
`ifdef LOG_MULT_SCHED_STATS_EN
  ,
  output logic [15:0]               stat_issued,
  output logic [15:0]               stat_zero
`endif
);

  localparam int unsigned ID_W  = $clog2(NREQ);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned RSV_W = $clog2(FIFO_DEPTH + DP_LAT + 2);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            neg;
    logic            zero;
  } tag_t;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [RES_W-1:0] data;
  } rsp_t;

  // Absolute value; the most negative input maps to its unsigned magnitude.
  function automatic logic [OP_W-1:0] mag_of(input logic [OP_W-1:0] v);
    return v[OP_W-1] ? (~v + OP_W'(1)) : v;
  endfunction

  logic [ID_W-1:0]  ptr;
  logic [NREQ-1:0]  grant;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  idx;
  logic             found;
  logic             accept;
  logic             can_grant;
  logic [RSV_W-1:0] reserved;

  logic [OP_W-1:0]  op_a [NREQ];
  logic [OP_W-1:0]  op_b [NREQ];
  logic [OP_W-1:0]  sel_a;
  logic [OP_W-1:0]  sel_b;
  logic             sel_zero;

  logic             iss_vld;
  tag_t             iss_tag;
  logic [DP_LAT-1:0] pipe_vld;
  tag_t             pipe_tag [DP_LAT];

  logic             wb_vld;
  tag_t             wb_tag;
  logic [RES_W-1:0] wb_mag;
  logic [RES_W-1:0] wb_data;

  rsp_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             push;
  logic             pop;

  // Split the packed operand buses into per-requester slices.
  for (genvar g = 0; g < NREQ; g++) begin : g_ops
    assign op_a[g] = req_a[g*OP_W +: OP_W];
    assign op_b[g] = req_b[g*OP_W +: OP_W];
  end

  // Credits held by the issue register, the tag pipe and the response FIFO.
  always_comb begin
    reserved = RSV_W'(iss_vld) + RSV_W'(fifo_count);
    for (int unsigned i = 0; i < DP_LAT; i++) begin
      reserved = reserved + RSV_W'(pipe_vld[i]);
    end
  end

  assign can_grant = rst_n & enable & (reserved < RSV_W'(FIFO_DEPTH));

  // Round-robin search starting at ptr, first valid requester wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    idx      = '0;
    found    = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = ID_W'((32'(ptr) + k) % NREQ);
      if (can_grant && !found && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

  assign req_ready = grant;
  assign accept    = found;
  assign sel_a     = op_a[grant_id];
  assign sel_b     = op_b[grant_id];
  assign sel_zero  = (sel_a == '0) || (sel_b == '0);

  // Round-robin pointer moves past the requester just served.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end

  // Issue stage: launch magnitudes to the datapath and capture the tag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iss_vld  <= 1'b0;
      iss_tag  <= '0;
      dp_valid <= 1'b0;
      dp_a     <= '0;
      dp_b     <= '0;
    end else begin
      iss_vld  <= accept;
      dp_valid <= accept & ~sel_zero;
      if (accept) begin
        dp_a         <= mag_of(sel_a);
        dp_b         <= mag_of(sel_b);
        iss_tag.id   <= grant_id;
        iss_tag.neg  <= sel_a[OP_W-1] ^ sel_b[OP_W-1];
        iss_tag.zero <= sel_zero;
      end
    end
  end

  // Tag pipe tracks the datapath latency so each tag meets its own result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int unsigned i = 0; i < DP_LAT; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_vld[0] <= iss_vld;
      pipe_tag[0] <= iss_tag;
      for (int unsigned i = 1; i < DP_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  // Writeback: zero ops ignore the datapath, then re-apply the sign.
  always_comb begin
    wb_vld  = pipe_vld[DP_LAT-1];
    wb_tag  = pipe_tag[DP_LAT-1];
    wb_mag  = wb_tag.zero ? '0 : dp_result;
    wb_data = wb_tag.neg ? (RES_W'(0) - wb_mag) : wb_mag;
  end

  assign push = wb_vld;
  assign pop  = rsp_valid & rsp_ready;

  // Response FIFO; the credit check guarantees a free slot on every push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr].id   <= wb_tag.id;
        fifo_mem[wr_ptr].data <= wb_data;
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + CNT_W'(1);
      end else if (!push && pop) begin
        fifo_count <= fifo_count - CNT_W'(1);
      end
    end
  end

  assign rsp_valid = (fifo_count != '0);
  assign rsp_id    = fifo_mem[rd_ptr].id;
  assign rsp_data  = fifo_mem[rd_ptr].data;
  assign idle      = (reserved == '0);

`ifdef LOG_MULT_SCHED_STATS_EN
  // Saturating counters of accepted and zero-bypassed ops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_issued <= '0;
      stat_zero   <= '0;
    end else if (accept) begin
      if (stat_issued != 16'hFFFF) stat_issued <= stat_issued + 16'd1;
      if (sel_zero && (stat_zero != 16'hFFFF)) stat_zero <= stat_zero + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_log_mult_scheduler.sv
// Directed testbench for log_mult_scheduler with an exact-multiply datapath model.
module tb_log_mult_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        dp_valid;
  logic [7:0]  dp_a;
  logic [7:0]  dp_b;
  logic [15:0] dp_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        idle;
`ifdef LOG_MULT_SCHED_STATS_EN
  logic [15:0] stat_issued;
  logic [15:0] stat_zero;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [15:0] exp_tab [4];

  log_mult_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .dp_valid  (dp_valid),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_result (dp_result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .idle      (idle)
`ifdef LOG_MULT_SCHED_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_zero   (stat_zero)
`endif
  );

  always #5 clk = ~clk;

  // Datapath model: exact product, 3-cycle latency; garbage when not launched.
  logic [15:0] s1, s2, s3;
  always @(posedge clk) begin
    s1 <= dp_valid ? ({8'h00, dp_a} * {8'h00, dp_b}) : 16'hDEAD;
    s2 <= s1;
    s3 <= s2;
  end
  assign dp_result = s3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response scoreboard: accepts push the hand-computed product, pops compare.
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        check("rsp_data", 32'(rsp_data), 32'(mon_e.data));
      end
    end
    if (!rst_n) begin
      sbq.delete();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) sbq.push_back({2'(i), exp_tab[i]});
      end
    end
  end

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    @(negedge clk);
    while (!idle && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(idle), 32'd1);
    check({tag, "_sb"}, 32'(sbq.size()), 32'd0);
    tick();
  endtask

  // Single op from an idle block, checking launch, latency, result and idle.
  task automatic one_op(input string tag, input int id, input logic [7:0] a, input logic [7:0] b,
                        input logic edv, input logic [7:0] ea, input logic [7:0] eb,
                        input logic [15:0] ed);
    exp_tab[id] = ed;
    req_a = '0;
    req_b = '0;
    req_a[id*8 +: 8] = a;
    req_b[id*8 +: 8] = b;
    req_valid = 4'b0001 << id;
    @(negedge clk);
    check({tag, "_gnt"}, 32'(req_ready), 32'(4'b0001 << id));
    tick();
    req_valid = '0;
    @(negedge clk);
    check({tag, "_dpv"}, 32'(dp_valid), 32'(edv));
    if (edv) begin
      check({tag, "_dpa"}, 32'(dp_a), 32'(ea));
      check({tag, "_dpb"}, 32'(dp_b), 32'(eb));
    end
    for (int k = 2; k <= 4; k++) begin
      tick();
      @(negedge clk);
      check({tag, "_early"}, 32'(rsp_valid), 32'd0);
    end
    tick();
    @(negedge clk);
    check({tag, "_rspv"}, 32'(rsp_valid), 32'd1);
    check({tag, "_id"}, 32'(rsp_id), 32'(id));
    check({tag, "_data"}, 32'(rsp_data), 32'(ed));
    tick();
    @(negedge clk);
    check({tag, "_idle"}, 32'(idle), 32'd1);
    check({tag, "_rspv0"}, 32'(rsp_valid), 32'd0);
    tick();
  endtask

  logic [3:0] gnt_free [10] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000,
                                4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] gnt_held [8]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000,
                                4'b0000, 4'b0000, 4'b0000};

  // Four requesters: 2*3, -5*7, 0*9, -12*-11.
  task automatic load_all();
    req_a = {8'hF4, 8'h00, 8'hFB, 8'h02};
    req_b = {8'hF5, 8'h09, 8'h07, 8'h03};
    exp_tab[0] = 16'h0006;
    exp_tab[1] = 16'hFFDD;
    exp_tab[2] = 16'h0000;
    exp_tab[3] = 16'h0084;
    req_valid = 4'b1111;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) exp_tab[i] = '0;
    rst_n     = 1'b0;
    enable    = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    tick();
    tick();
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_dpv", 32'(dp_valid), 32'd0);
    check("rst_dpa", 32'(dp_a), 32'd0);
    check("rst_rspv", 32'(rsp_valid), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_data", 32'(rsp_data), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    req_valid = '0;
    rst_n     = 1'b1;
    tick();

    one_op("t1", 0, 8'd3, 8'd5, 1'b1, 8'd3, 8'd5, 16'd15);
    one_op("t2a", 2, 8'hFC, 8'd6, 1'b1, 8'd4, 8'd6, 16'hFFE8);
    one_op("t2b", 2, 8'h80, 8'h80, 1'b1, 8'd128, 8'd128, 16'd16384);
    one_op("t3", 1, 8'h00, 8'hF9, 1'b0, 8'd0, 8'd0, 16'h0000);

    enable    = 1'b0;
    req_valid = 4'b1111;
    @(negedge clk);
    check("en_off", 32'(req_ready), 32'd0);
    tick();
    enable    = 1'b1;
    req_valid = '0;

    // Round-robin stream with the credit limit throttling issue.
    do_reset();
    load_all();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("rr_gnt%0d", c), 32'(req_ready), 32'(gnt_free[c]));
      tick();
    end
    req_valid = '0;
    wait_idle("rr_drain", 40);

    // Back-pressure: four credits only, then resume one cycle after the first pop.
    do_reset();
    rsp_ready = 1'b0;
    load_all();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("bp_gnt%0d", c), 32'(req_ready), 32'(gnt_held[c]));
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_pop_gnt", 32'(req_ready), 32'd0);
    check("bp_head_v", 32'(rsp_valid), 32'd1);
    check("bp_head_id", 32'(rsp_id), 32'd0);
    tick();
    @(negedge clk);
    check("bp_resume", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    wait_idle("bp_drain", 40);

    // Reset with two ops in flight: nothing stale may surface.
    do_reset();
    exp_tab[3] = 16'd4;
    exp_tab[0] = 16'd1;
    req_a = {8'd2, 8'd0, 8'd0, 8'd1};
    req_b = {8'd2, 8'd0, 8'd0, 8'd1};
    req_valid = 4'b1000;
    @(negedge clk);
    check("fl_gnt3", 32'(req_ready), 32'b1000);
    tick();
    req_valid = 4'b0001;
    @(negedge clk);
    check("fl_gnt0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("fl_busy", 32'(idle), 32'd0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("fl_rspv", 32'(rsp_valid), 32'd0);
    check("fl_idle", 32'(idle), 32'd1);
    check("fl_dpv", 32'(dp_valid), 32'd0);
    for (int c = 0; c < 8; c++) begin
      tick();
      @(negedge clk);
      check("fl_stale", 32'(rsp_valid), 32'd0);
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
